// File: rtl/ir_xmit.sv
// ir_xmit: NEC infrared transmitter (full frames + repeat codes) on clk27.
// Define IR_XMIT_CARRIER_EN for a carrier-modulated LED-drive output.
module ir_xmit #(
  parameter int UNIT_CYCLES    = 15188,
  parameter int GAP_UNITS      = 72
`ifdef IR_XMIT_CARRIER_EN
  ,
  parameter int CARRIER_PERIOD = 711,
  parameter int CARRIER_HIGH   = 237
`endif
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic [15:0] code_in,
  input  logic        rpt_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  tx_cnt,
  output logic        ir_tx
);

  localparam int UW = (UNIT_CYCLES > 1) ?
                      $clog2(UNIT_CYCLES) : 1;
  localparam int MAXU = (GAP_UNITS > 16) ?
                        GAP_UNITS : 16;
  localparam int MW = $clog2(MAXU + 1);
  localparam logic [UW-1:0] U_LAST =
    UW'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } state_t;

  state_t        state;
  logic [UW-1:0] ucnt;
  logic [MW-1:0] mcnt;
  logic [31:0]   data;
  logic [4:0]    bidx;
  logic          rpt;
  logic          expire;

  assign expire = (ucnt == '0) && (mcnt == '0);

`ifdef IR_XMIT_CARRIER_EN
  localparam logic MRK = 1'b1;
  localparam logic SPC = 1'b0;
  localparam int CW = (CARRIER_PERIOD > 1) ?
                      $clog2(CARRIER_PERIOD) : 1;

  logic [CW-1:0] ph;
  logic [CW-1:0] ph_nxt;
  logic          is_mark;

  assign ph_nxt = (ph == CW'(CARRIER_PERIOD - 1)) ?
                  '0 : ph + 1'b1;
  assign is_mark = (state == LEAD_MARK) ||
                   (state == BIT_MARK)  ||
                   (state == STOP_MARK);
`else
  localparam logic MRK = 1'b0;
  localparam logic SPC = 1'b1;
`endif

  // Counters run down; reaching 0/0 is the last cycle of a state.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      tx_cnt <= '0;
      ir_tx  <= SPC;
      ucnt   <= '0;
      mcnt   <= '0;
      data   <= '0;
      bidx   <= '0;
      rpt    <= 1'b0;
`ifdef IR_XMIT_CARRIER_EN
      ph     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= LEAD_MARK;
          busy  <= 1'b1;
          ir_tx <= MRK;
          ucnt  <= U_LAST;
          mcnt  <= MW'(15);
          rpt   <= rpt_in;
          bidx  <= '0;
          data  <= {~code_in[7:0],
                    code_in[7:0],
                    ~code_in[15:8],
                    code_in[15:8]};
`ifdef IR_XMIT_CARRIER_EN
          ph    <= '0;
`endif
        end
      end else if (!expire) begin
        if (ucnt != '0) begin
          ucnt <= ucnt - 1'b1;
        end else begin
          ucnt <= U_LAST;
          mcnt <= mcnt - 1'b1;
        end
`ifdef IR_XMIT_CARRIER_EN
        if (is_mark) begin
          ph    <= ph_nxt;
          ir_tx <= (ph_nxt < CW'(CARRIER_HIGH));
        end
`endif
      end else begin
        ucnt <= U_LAST;
`ifdef IR_XMIT_CARRIER_EN
        ph   <= '0;
`endif
        unique case (state)
          LEAD_MARK: begin
            state <= LEAD_SPACE;
            ir_tx <= SPC;
            mcnt  <= rpt ? MW'(3) : MW'(7);
          end
          LEAD_SPACE: begin
            state <= rpt ? STOP_MARK : BIT_MARK;
            ir_tx <= MRK;
            mcnt  <= '0;
          end
          BIT_MARK: begin
            state <= BIT_SPACE;
            ir_tx <= SPC;
            mcnt  <= data[0] ? MW'(2) : MW'(0);
          end
          BIT_SPACE: begin
            state <= (bidx == 5'd31) ?
                     STOP_MARK : BIT_MARK;
            ir_tx <= MRK;
            mcnt  <= '0;
            data  <= data >> 1;
            bidx  <= bidx + 5'd1;
          end
          STOP_MARK: begin
            state <= GAP;
            ir_tx <= SPC;
            mcnt  <= MW'(GAP_UNITS - 1);
          end
          GAP: begin
            state  <= IDLE;
            ir_tx  <= SPC;
            busy   <= 1'b0;
            done   <= 1'b1;
            tx_cnt <= tx_cnt + 8'd1;
            ucnt   <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_xmit.sv
// tb_ir_xmit: directed bench for ir_xmit with UNIT_CYCLES=4, GAP_UNITS=2.
// Waveform checks assume baseband unless IR_XMIT_CARRIER_EN is defined.
`timescale 1ns/1ps
module tb_ir_xmit;

`ifdef IR_XMIT_CARRIER_EN
  localparam logic SPC = 1'b0;
  localparam logic MRK = 1'b1;
`else
  localparam logic SPC = 1'b1;
  localparam logic MRK = 1'b0;
`endif

  logic        clk27 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] code_in = '0;
  logic        rpt_in = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  tx_cnt;
  logic        ir_tx;

  int n_run = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  logic w  [0:1023];
  logic bz [0:1023];
  logic dn [0:1023];
  int   rl [0:127];
  logic rv [0:127];
  int   nr;
  int   busy_len;
  int   done_at;
  int   done_cnt;

  ir_xmit #(
    .UNIT_CYCLES(4),
    .GAP_UNITS(2)
`ifdef IR_XMIT_CARRIER_EN
    ,
    .CARRIER_PERIOD(3),
    .CARRIER_HIGH(1)
`endif
  ) dut (
    .clk27(clk27),
    .reset_n(reset_n),
    .code_in(code_in),
    .rpt_in(rpt_in),
    .start(start),
    .busy(busy),
    .done(done),
    .tx_cnt(tx_cnt),
    .ir_tx(ir_tx)
  );

  always #5 clk27 = ~clk27;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // k = cycles after the accepting edge; optional ignored start at restart_at
  task automatic capture(input logic [15:0] code,
                         input logic rpt,
                         input int n,
                         input int restart_at);
    @(negedge clk27);
    code_in = code;
    rpt_in  = rpt;
    start   = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk27);
      start = (k == restart_at);
      if (k == restart_at) begin
        code_in = ~code;
        rpt_in  = ~rpt;
      end
      w[k]  = ir_tx;
      bz[k] = busy;
      dn[k] = done;
    end
    start = 1'b0;
    nr = 0;
    busy_len = 0;
    done_at = 0;
    done_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      if (bz[k] === 1'b1 && busy_len == k - 1) busy_len = k;
      if (dn[k] === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k == 1) begin
        rv[0] = w[1];
        rl[0] = 1;
        nr = 1;
      end else if (w[k] !== w[k-1] && nr < 128) begin
        rv[nr] = w[k];
        rl[nr] = 1;
        nr++;
      end else begin
        rl[nr-1]++;
      end
    end
  endtask

  task automatic decode(output logic [31:0] word,
                        output logic bad);
    word = '0;
    bad  = (nr < 67);
    for (int i = 0; i < 32; i++) begin
      if (rv[2+2*i] !== 1'b0 || rl[2+2*i] != 4) bad = 1'b1;
      if (rl[3+2*i] == 12) word[i] = 1'b1;
      else if (rl[3+2*i] != 4) bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    int errs;
    errs = 0;
    repeat (3) @(negedge clk27);
    n_run++;
    if (ir_tx !== SPC || busy !== 1'b0 ||
        done !== 1'b0 || tx_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got ir_tx=%b busy=%b done=%b cnt=%0d, want %b/0/0/0",
               ir_tx, busy, done, tx_cnt, SPC);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk27);
      if (ir_tx !== SPC || busy !== 1'b0 ||
          done !== 1'b0 || tx_cnt !== 8'd0) errs++;
    end
    n_run++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d bad idle cycles, want 0", errs);
    end
  endtask

  task automatic test_full();
    logic [31:0] word;
    logic bad;
    capture(16'h00FF, 1'b0, 500, 0);
    exp_cnt++;
    n_run++;
    if (rv[0] !== 1'b0 || rl[0] != 64) begin
      n_fail++;
      $display("FAIL full_lead_mark: got lvl=%b len=%0d, want 0/64", rv[0], rl[0]);
    end
    n_run++;
    if (rl[1] != 32) begin
      n_fail++;
      $display("FAIL full_lead_space: got %0d, want 32", rl[1]);
    end
    decode(word, bad);
    n_run++;
    if (bad || word !== 32'h00FFFF00) begin
      n_fail++;
      $display("FAIL full_bits: got %h bad=%b, want 00ffff00 bad=0", word, bad);
    end
    n_run++;
    if (rv[66] !== 1'b0 || rl[66] != 4) begin
      n_fail++;
      $display("FAIL full_stop: got lvl=%b len=%0d, want 0/4", rv[66], rl[66]);
    end
    n_run++;
    if (busy_len != 492) begin
      n_fail++;
      $display("FAIL full_busy: got %0d, want 492", busy_len);
    end
    n_run++;
    if (done_cnt != 1 || done_at != 493) begin
      n_fail++;
      $display("FAIL full_done: got cnt=%0d at=%0d, want 1 at 493", done_cnt, done_at);
    end
    n_run++;
    if (tx_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL full_cnt: got %0d, want %0d", tx_cnt, exp_cnt);
    end
  endtask

  task automatic test_repeat();
    capture(16'h1234, 1'b1, 100, 0);
    exp_cnt++;
    n_run++;
    if (rv[0] !== 1'b0 || rl[0] != 64 || rl[1] != 16 ||
        rv[2] !== 1'b0 || rl[2] != 4 || rv[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rpt_wave: got %0d/%0d/%0d lvl3=%b, want 64/16/4 lvl3=1",
               rl[0], rl[1], rl[2], rv[3]);
    end
    n_run++;
    if (busy_len != 92 || done_at != 93 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL rpt_busy: got busy=%0d done_at=%0d n=%0d, want 92/93/1",
               busy_len, done_at, done_cnt);
    end
    n_run++;
    if (tx_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL rpt_cnt: got %0d, want %0d", tx_cnt, exp_cnt);
    end
  endtask

  task automatic test_restart();
    logic [31:0] word;
    logic bad;
    capture(16'hA53C, 1'b0, 500, 100);
    exp_cnt++;
    decode(word, bad);
    n_run++;
    if (bad || word !== 32'hC33C5AA5) begin
      n_fail++;
      $display("FAIL restart_bits: got %h bad=%b, want c33c5aa5 bad=0", word, bad);
    end
    n_run++;
    if (busy_len != 492 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL restart_busy: got %0d/%0d, want 492/1", busy_len, done_cnt);
    end
    n_run++;
    if (tx_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL restart_cnt: got %0d, want %0d", tx_cnt, exp_cnt);
    end
  endtask

  task automatic test_carrier();
    int errs;
    logic e;
    errs = 0;
    capture(16'h0000, 1'b1, 95, 0);
    exp_cnt++;
    for (int k = 1; k <= 92; k++) begin
      if (k <= 64) e = ((k - 1) % 3 == 0);
      else if (k <= 80) e = 1'b0;
      else if (k <= 84) e = ((k - 81) % 3 == 0);
      else e = 1'b0;
      if (w[k] !== e) errs++;
    end
    n_run++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL carrier_wave: got %0d bad cycles, want 0", errs);
    end
    n_run++;
    if (busy_len != 92 || done_at != 93) begin
      n_fail++;
      $display("FAIL carrier_busy: got %0d/%0d, want 92/93", busy_len, done_at);
    end
  endtask

  task automatic test_back_to_back();
    logic got;
    @(negedge clk27);
    rpt_in = 1'b1;
    start  = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk27);
      start = 1'b0;
      if (done === 1'b1) got = 1'b1;
    end
    exp_cnt++;
    n_run++;
    if (!got) begin
      n_fail++;
      $display("FAIL b2b_done1: got timeout, want done");
    end
    start = 1'b1;
    @(negedge clk27);
    start = 1'b0;
    n_run++;
    if (busy !== 1'b1 || ir_tx !== MRK) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b ir_tx=%b, want 1/%b", busy, ir_tx, MRK);
    end
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk27);
      if (done === 1'b1) got = 1'b1;
    end
    exp_cnt++;
    n_run++;
    if (!got || tx_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL b2b_cnt: got done=%b cnt=%0d, want 1/%0d", got, tx_cnt, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    int errs;
    errs = 0;
    @(negedge clk27);
    code_in = 16'h00FF;
    rpt_in  = 1'b0;
    start   = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk27);
      start = 1'b0;
    end
    n_run++;
    if (busy !== 1'b1 || ir_tx !== SPC) begin
      n_fail++;
      $display("FAIL arst_pre: got busy=%b ir_tx=%b, want 1/%b", busy, ir_tx, SPC);
    end
    @(negedge clk27);
    reset_n = 1'b0;
    #1;
    exp_cnt = 0;
    n_run++;
    if (ir_tx !== SPC || busy !== 1'b0 ||
        done !== 1'b0 || tx_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL arst_now: got ir_tx=%b busy=%b done=%b cnt=%0d, want %b/0/0/0",
               ir_tx, busy, done, tx_cnt, SPC);
    end
    repeat (3) @(negedge clk27);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk27);
      if (done !== 1'b0 || busy !== 1'b0 || tx_cnt !== 8'd0) errs++;
    end
    n_run++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL arst_after: got %0d bad cycles, want 0", errs);
    end
  endtask

  task automatic test_wrap();
    logic got;
    logic ok;
    ok = 1'b1;
    @(negedge clk27);
    rpt_in = 1'b1;
    start  = 1'b1;
    for (int f = 1; f <= 256 && ok; f++) begin
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk27);
        start = 1'b0;
        if (done === 1'b1) got = 1'b1;
      end
      if (!got) ok = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      if (f < 256) start = 1'b1;
      if (f == 255) begin
        n_run++;
        if (tx_cnt !== 8'hFF) begin
          n_fail++;
          $display("FAIL wrap_ff: got %h, want ff", tx_cnt);
        end
      end
    end
    start = 1'b0;
    n_run++;
    if (!ok || tx_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_00: got done_ok=%b cnt=%h, want 1/00", ok, tx_cnt);
    end
  endtask

  initial begin
    test_reset();
`ifdef IR_XMIT_CARRIER_EN
    test_carrier();
`else
    test_full();
    test_repeat();
    test_restart();
`endif
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_xmit.md
Name: ir_xmit

Overview:
- NEC-protocol infrared transmitter; the encoding counterpart of ir_rcv.
- Clocked from clk27 and driven by the CPU through a PIO.
- Produces a baseband IR waveform with the same polarity as the receiver module output (idle high, mark low). This allows loopback self-test into ir_rx and driving an external IR LED for device control.
- Supports full frames and NEC repeat codes, and reports completion and a frame count.

Parameters:
- UNIT_CYCLES, 15188, clk27 cycles per NEC time unit (562.5 us at 27 MHz).
- GAP_UNITS, 72, minimum idle units after the stop mark before the next frame can start.
- CARRIER_PERIOD, 711, carrier period in cycles (about 38 kHz); used only with IR_XMIT_CARRIER_EN.
- CARRIER_HIGH, 237, carrier high cycles per period (1/3 duty); used only with IR_XMIT_CARRIER_EN.

Ports:
- clk27  in  1  system clock, 27 MHz.
- reset_n  in  1  asynchronous active-low reset.
- code_in  in  16  [15:8] = address, [7:0] = command.
- rpt_in  in  1  at start, 1 = send a repeat code and ignore code_in.
- start  in  1  single-cycle request.
- busy  out  1  high from acceptance until the gap ends.
- done  out  1  one-cycle pulse at frame completion.
- tx_cnt  out  8  completed-frame counter; wraps 0xFF -> 0x00.
- ir_tx  out  1  IR waveform; baseband default is 1 = idle/space, 0 = mark.

Behaviour:
- Reset (async): state IDLE, ir_tx=1, busy=0, done=0, tx_cnt=0, all counters 0. Reset mid-frame aborts immediately with no done pulse.
- Acceptance: start is sampled on a clk27 edge only when busy=0. code_in and rpt_in are latched on that edge.
- start while busy=1 is ignored; it is not queued.
- Cycle N accept -> at N+1: busy=1, state LEAD_MARK, ir_tx=0.
- States and durations (1 unit = UNIT_CYCLES cycles):
  - LEAD_MARK: 16 units, ir_tx=0.
  - LEAD_SPACE: 8 units, or 4 units if rpt latched. Then BIT_MARK, or STOP_MARK if rpt.
  - BIT_MARK: 1 unit, ir_tx=0.
  - BIT_SPACE: 1 unit for bit 0, 3 units for bit 1, ir_tx=1. After bit 31 go to STOP_MARK, otherwise BIT_MARK.
  - STOP_MARK: 1 unit, ir_tx=0.
  - GAP: GAP_UNITS units, ir_tx=1.
  - IDLE.
- Data word: 32 bits sent LSB-first in the order addr, ~addr, cmd, ~cmd. Complements are formed at latch time.
- The 32-bit data section always contains 16 ones and 16 zeros, so it lasts exactly 96 units.
- Frame lengths: full frame mark/space = 121 units. Busy time = (121+GAP_UNITS)*UNIT_CYCLES cycles. Repeat code busy time = (21+GAP_UNITS)*UNIT_CYCLES cycles.
- Every state duration is exact to the cycle: no slip at state boundaries, and the unit counter reloads on each transition.
- Completion: on the last GAP cycle the block goes to IDLE, and on that same edge busy->0, done=1 for one cycle, and tx_cnt increments (mod 256).
- A start arriving in the cycle after done is accepted.
- Counter widths: unit counter is ceil(log2(UNIT_CYCLES)) bits; the unit-multiple counter is wide enough for max(16, GAP_UNITS).

Optional Feature:
- Macro: IR_XMIT_CARRIER_EN.
- When defined:
  - ir_tx becomes LED-drive polarity: 0 = off.
  - During marks, ir_tx is a free-running carrier: high for CARRIER_HIGH cycles of each CARRIER_PERIOD.
  - The carrier counter restarts at 0 on the first cycle of each mark, so every mark begins with a high phase.
  - During spaces and idle, and at reset, ir_tx=0.
- When undefined: baseband behaviour as above, with no carrier logic synthesized.

Test Plan (UNIT_CYCLES=4, GAP_UNITS=2):
- Reset release, no start -> ir_tx=1, busy=0, tx_cnt=0 indefinitely.
- start with code_in=0x00FF, rpt_in=0:
  - ir_tx low for 64 cycles, then high for 32 cycles.
  - Decoded bits read back as 00, FF, FF, 00 (LSB-first).
  - Stop mark of 4 cycles, then busy falls 492 cycles after accept.
  - done pulses once and tx_cnt=1.
- start with rpt_in=1 -> 64 low, 16 high, 4 low, 8 high; busy lasts 92 cycles; tx_cnt increments.
- start re-pulsed mid-frame -> waveform unchanged, tx_cnt increments only once. start on the cycle after done -> a new frame begins at the next cycle.
- reset_n asserted during BIT_SPACE -> ir_tx=1 and busy=0 immediately (asynchronous), no done pulse, tx_cnt=0.
- 256 back-to-back repeat frames -> tx_cnt wraps to 0x00. With IR_XMIT_CARRIER_EN and CARRIER_PERIOD=3, CARRIER_HIGH=1, each mark reads 1,0,0 repeating, and spaces read 0.
